uart_hex_block_rx: RTL and testbench
====================================

Name: uart_hex_block_rx

Overview:
- Receive-side counterpart of the AES result transmit path.
- Deserialises 8N1 UART characters on rxd, decodes ASCII hex digits to nibbles, and assembles BLOCK_SIZE-bit words, most significant nibble first.
- Delivers each completed word, with a one-cycle valid strobe, to the AES plaintext or key input registers.
- Sits beside baud_rate_gen, which supplies a sample_tick at OVERSAMPLE× the baud rate.

Parameters:
- DATA_SIZE, 8, UART data bits per character.
- BLOCK_SIZE, 128, assembled word width; must be a multiple of 4.
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, ≥4.

Ports:
- clk  input  1  system clock (50 MHz FPGA clock).
- reset  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-clk strobe at OVERSAMPLE×baud from baud_rate_gen.
- rxd  input  1  asynchronous UART RX line, idle high.
- block_out  output  BLOCK_SIZE  last completed word.
- block_valid  output  1  one-clk pulse when block_out is updated.
- char_err  output  1  one-clk pulse on a framing, parity, or non-hex error.
- busy  output  1  high while a character frame is in progress.

Behaviour:
- Reset values: block_out=0, block_valid=0, char_err=0, busy=0, FSM=IDLE, nibble count=0, shift register=0, synchroniser=2'b11.
- rxd passes through a 2-FF synchroniser; all decisions use the synchronised value.
- All counters advance only on sample_tick; FSM transitions occur on clk edges with sample_tick=1.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- IDLE:
  - Synchronised rxd=0 on a tick → START, tick counter cleared.
- START:
  - After OVERSAMPLE/2 ticks (mid start bit), rxd resampled.
  - If rxd=1: false start, return to IDLE, no error.
  - If rxd=0: → DATA.
- DATA:
  - One sample every OVERSAMPLE ticks, LSB first.
  - After DATA_SIZE samples → STOP (or PARITY).
- STOP:
  - Sample taken after OVERSAMPLE ticks.
  - If rxd=1: the character is accepted for decoding.
  - If rxd=0: framing error; char_err pulses, the character is discarded, and the FSM waits for rxd=1 before returning to IDLE (break handling).
- busy is high in every state except IDLE.
- Decode of an accepted character, one clk after the stop sample:
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66) produce nibble 0-F.
  - The nibble shifts into the low end of the accumulator (shift left by 4), and the nibble count increments.
  - 0x0D and 0x0A resynchronise: nibble count=0, partial word discarded, no error.
  - Any other byte: char_err pulse, byte ignored, count unchanged.
- Block completion:
  - On the BLOCK_SIZE/4-th nibble, block_out takes the full accumulator in the same clk as the shift.
  - block_valid pulses for exactly one clk, and the count wraps to 0.
  - block_out holds its value until the next completion.
- Reset asserted mid-frame or mid-block clears everything immediately; the partial word is lost and no pulse is emitted.
- Latency: block_valid is asserted 2 clk after the sample_tick that samples the last character's stop bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; one even-parity bit is sampled.
  - On mismatch, char_err pulses and the character is discarded after the stop bit; a framing error is still reported once.
- Undefined: 8N1 only; no PARITY state and no parity logic synthesised.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - ASCII constants ASCII_0, ASCII_9, ASCII_UA, ASCII_UF, ASCII_LA, ASCII_LF, ASCII_CR, ASCII_LF_CHAR.
  - NIBBLE_W=4.
- One sub-module: ascii_to_num.
  - Combinational; the inverse of num_to_ASCII.
  - Outputs num[3:0] and is_hex, is_eol flags.
- The FSM and accumulator stay in uart_hex_block_rx.

Test Plan:
- Stimulus: send "00112233445566778899AABBCCDDEEFF" at 9600 baud, 16× ticks. Response: one block_valid, block_out=128'h00112233445566778899aabbccddeeff, char_err never asserted.
- Stimulus: send 10 hex characters, then 0x0D, then 32 characters "000102030405060708090a0b0c0d0e0f". Response: single block_valid, block_out=128'h000102030405060708090a0b0c0d0e0f; the 10 prior nibbles are absent.
- Stimulus: in the middle of a 32-character block, insert 'G' (0x47). Response: one char_err pulse, the block still completes after 32 valid digits, and the value is unchanged by 'G'.
- Stimulus: a start-bit glitch low for 4 ticks (< OVERSAMPLE/2), then a normal character '5'. Response: no char_err, and exactly one nibble 5 is accumulated.
- Stimulus: drive stop bit=0 on character 'A'. Response: char_err pulse, nibble not counted, and the receiver recovers for the next character after rxd returns high.
- Stimulus: assert reset after 20 characters, release, then send 32 characters of 'F'. Response: block_valid once, block_out=128'hFFFF…FF (all ones), with no spurious pulse at reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART hex block receiver.
// Holds the receive FSM encoding and the ASCII code points used by the hex decoder.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int NIBBLE_W = 4;

    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UA      = 8'h41;
    localparam logic [7:0] ASCII_UF      = 8'h46;
    localparam logic [7:0] ASCII_LA      = 8'h61;
    localparam logic [7:0] ASCII_LF      = 8'h66;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF_CHAR = 8'h0A;

endpackage

// File: rtl/ascii_to_num.sv
// Combinational ASCII hex digit decoder, the inverse of num_to_ASCII.
// Flags hex digits (either case) and CR/LF end-of-line characters.
module ascii_to_num (
    input  logic [7:0] ascii,
    output logic [3:0] num,
    output logic       is_hex,
    output logic       is_eol
);
    import uart_pkg::*;

    // Classify the byte and map hex digits to their 4-bit value
    always_comb begin
        num    = 4'h0;
        is_hex = 1'b0;
        is_eol = 1'b0;
        if ((ascii >= ASCII_0) && (ascii <= ASCII_9)) begin
            num    = 4'(ascii - ASCII_0);
            is_hex = 1'b1;
        end else if ((ascii >= ASCII_UA) && (ascii <= ASCII_UF)) begin
            num    = 4'(ascii - ASCII_UA + 8'd10);
            is_hex = 1'b1;
        end else if ((ascii >= ASCII_LA) && (ascii <= ASCII_LF)) begin
            num    = 4'(ascii - ASCII_LA + 8'd10);
            is_hex = 1'b1;
        end else if ((ascii == ASCII_CR) || (ascii == ASCII_LF_CHAR)) begin
            is_eol = 1'b1;
        end else begin
            is_hex = 1'b0;
        end
    end

endmodule

// File: rtl/uart_hex_block_rx.sv
// UART receiver that turns a stream of ASCII hex digits into BLOCK_SIZE-bit words.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_hex_block_rx #(
    parameter int DATA_SIZE  = 8,
    parameter int BLOCK_SIZE = 128,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rxd,
    output logic [BLOCK_SIZE-1:0] block_out,
    output logic                  block_valid,
    output logic                  char_err,
    output logic                  busy
);
    import uart_pkg::*;

    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_SIZE + 1);
    localparam int NIBBLES = BLOCK_SIZE / NIBBLE_W;
    localparam int NCNT_W  = $clog2(NIBBLES + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);
    localparam logic [NCNT_W-1:0] NIB_LAST  = NCNT_W'(NIBBLES - 1);

    logic [1:0]            sync_r;
    logic                  rxd_s;
    rx_state_t             state_r, state_s;
    logic [TICK_W-1:0]     tick_cnt_r, tick_cnt_s;
    logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_s;
    logic [DATA_SIZE-1:0]  shift_r, shift_s;
    logic                  brk_r, brk_s;
    logic                  char_ready_r, char_ready_s;
    logic                  bad_char_s;
`ifdef UART_RX_PARITY_EN
    logic                  par_err_r, par_err_s;
`endif

    logic [7:0]            char_byte_s;
    logic [3:0]            nib_s;
    logic                  is_hex_s, is_eol_s;
    logic [BLOCK_SIZE-1:0] acc_r, acc_shift_s;
    logic [NCNT_W-1:0]     nib_cnt_r;
    logic [BLOCK_SIZE-1:0] block_out_r;
    logic                  block_valid_r, char_err_r, busy_r;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity_err(input logic [DATA_SIZE-1:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction
`endif

    assign rxd_s       = sync_r[1];
    assign char_byte_s = 8'(shift_r);
    assign acc_shift_s = {acc_r[BLOCK_SIZE-NIBBLE_W-1:0], nib_s};

    // Frame FSM next state: start detect, mid-bit sampling and stop/break handling
    always_comb begin
        state_s      = state_r;
        tick_cnt_s   = tick_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        brk_s        = brk_r;
        char_ready_s = 1'b0;
        bad_char_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_s    = par_err_r;
`endif
        if (sample_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rxd_s) begin
                        state_s    = START;
                        tick_cnt_s = {TICK_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        bit_cnt_s  = {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                        par_err_s  = 1'b0;
`endif
                        // A line that is high again at mid start bit was only a glitch
                        state_s    = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        shift_s    = {rxd_s, shift_r[DATA_SIZE-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_s = PARITY;
`else
                            state_s = STOP;
`endif
                        end else begin
                            bit_cnt_s = bit_cnt_r + 1'b1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        par_err_s  = even_parity_err(shift_r, rxd_s);
                        state_s    = STOP;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (brk_r) begin
                        // Break: hold here until the line idles high again
                        if (rxd_s) begin
                            brk_s   = 1'b0;
                            state_s = IDLE;
                        end else begin
                            state_s = STOP;
                        end
                    end else if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        if (rxd_s) begin
                            state_s = IDLE;
`ifdef UART_RX_PARITY_EN
                            char_ready_s = !par_err_r;
                            bad_char_s   = par_err_r;
`else
                            char_ready_s = 1'b1;
`endif
                        end else begin
                            bad_char_s = 1'b1;
                            brk_s      = 1'b1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Synchroniser and frame FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r       <= 2'b11;
            state_r      <= IDLE;
            tick_cnt_r   <= {TICK_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            shift_r      <= {DATA_SIZE{1'b0}};
            brk_r        <= 1'b0;
            char_ready_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r    <= 1'b0;
`endif
        end else begin
            sync_r       <= {sync_r[0], rxd};
            state_r      <= state_s;
            tick_cnt_r   <= tick_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            brk_r        <= brk_s;
            char_ready_r <= char_ready_s;
`ifdef UART_RX_PARITY_EN
            par_err_r    <= par_err_s;
`endif
        end
    end

    ascii_to_num u_ascii_to_num (
        .ascii  (char_byte_s),
        .num    (nib_s),
        .is_hex (is_hex_s),
        .is_eol (is_eol_s)
    );

    // Nibble accumulator, block completion and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r         <= {BLOCK_SIZE{1'b0}};
            nib_cnt_r     <= {NCNT_W{1'b0}};
            block_out_r   <= {BLOCK_SIZE{1'b0}};
            block_valid_r <= 1'b0;
            char_err_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            block_valid_r <= 1'b0;
            char_err_r    <= bad_char_s;
            busy_r        <= (state_s != IDLE);
            if (char_ready_r) begin
                if (is_hex_s) begin
                    if (nib_cnt_r == NIB_LAST) begin
                        block_out_r   <= acc_shift_s;
                        block_valid_r <= 1'b1;
                        acc_r         <= {BLOCK_SIZE{1'b0}};
                        nib_cnt_r     <= {NCNT_W{1'b0}};
                    end else begin
                        acc_r     <= acc_shift_s;
                        nib_cnt_r <= nib_cnt_r + 1'b1;
                    end
                end else if (is_eol_s) begin
                    acc_r     <= {BLOCK_SIZE{1'b0}};
                    nib_cnt_r <= {NCNT_W{1'b0}};
                end else begin
                    char_err_r <= 1'b1;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign block_out   = block_out_r;
    assign block_valid = block_valid_r;
    assign char_err    = char_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_hex_block_rx.sv
// Self-checking bench for uart_hex_block_rx: directed and random 8N1 traffic compared
// against a character-level model of the hex-to-block assembly rules.
module tb_uart_hex_block_rx;

    localparam int OS       = 16;
    localparam int TICK_DIV = 2;
    localparam int BIT_CLK  = OS * TICK_DIV;

    logic         clk, reset, sample_tick, rxd;
    logic [127:0] block_out;
    logic         block_valid, char_err, busy;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];
    int           err_seen = 0;
    int           exp_err  = 0;
    logic [127:0] last_blk = 128'd0;
    logic [127:0] m_acc    = 128'd0;
    int           m_cnt    = 0;
    int           tick_ph  = 0;
    string        hexs     = "0123456789abcdefABCDEF";

    uart_hex_block_rx #(
        .DATA_SIZE  (8),
        .BLOCK_SIZE (128),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rxd         (rxd),
        .block_out   (block_out),
        .block_valid (block_valid),
        .char_err    (char_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_ph++;
            sample_tick = ((tick_ph % TICK_DIV) == 0);
        end
    end

    // Every clk a strobe is high counts once, so a stretched pulse shows up as extra events
    always @(negedge clk) begin
        if (block_valid) begin
            got_q.push_back(block_out);
            last_blk = block_out;
        end
        if (char_err) err_seen++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_char(input logic [7:0] c, input bit stop_ok);
        int v;
        if (!stop_ok) begin
            exp_err++;
            return;
        end
        v = hexval(c);
        if (v >= 0) begin
            m_acc = (m_acc << 4) | 128'(v);
            m_cnt++;
            if (m_cnt == 32) begin
                exp_q.push_back(m_acc);
                m_acc = 128'd0;
                m_cnt = 0;
            end
        end else if (c == 8'h0D || c == 8'h0A) begin
            m_acc = 128'd0;
            m_cnt = 0;
        end else begin
            exp_err++;
        end
    endtask

    task automatic send_byte(input logic [7:0] c, input bit stop_ok, input bit probe_busy);
        model_char(c, stop_ok);
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        if (probe_busy) check("busy_mid", busy, 1'b1);
        for (int b = 0; b < 8; b++) begin
            rxd = c[b];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (stop_ok ? 4 : BIT_CLK) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0);
    endtask

    task automatic glitch();
        rxd = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    task automatic check_phase(input string ph);
        repeat (BIT_CLK) @(negedge clk);
        check({ph, "_nblk"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({ph, "_blk"}, got_q.pop_front(), exp_q.pop_front());
        check({ph, "_err"}, err_seen, exp_err);
        check({ph, "_busy"}, busy, 1'b0);
        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    task automatic pulse_reset(input string ph);
        reset = 1'b1;
        m_acc = 128'd0;
        m_cnt = 0;
        repeat (3) @(negedge clk);
        check({ph, "_blk0"}, block_out, 128'd0);
        check({ph, "_valid0"}, block_valid, 1'b0);
        check({ph, "_err0"}, char_err, 1'b0);
        check({ph, "_busy0"}, busy, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (2) @(negedge clk);
        pulse_reset("rst");

        // Full block in one go
        send_byte("0", 1'b1, 1'b1);
        send_str("0112233445566778899AABBCCDDEEFF");
        check_phase("t1");
        check("t1_const", last_blk, 128'h00112233445566778899aabbccddeeff);

        // CR discards a partial word
        send_str("0123456789");
        send_byte(8'h0D, 1'b1, 1'b0);
        send_str("000102030405060708090a0b0c0d0e0f");
        check_phase("t2");
        check("t2_const", last_blk, 128'h000102030405060708090a0b0c0d0e0f);

        // Non-hex character in the middle of a block
        send_str("fedcba9876543210");
        send_byte(8'h47, 1'b1, 1'b0);
        send_str("0123456789ABCDEF");
        check_phase("t3");
        check("t3_const", last_blk, 128'hfedcba98765432100123456789abcdef);

        // Short start glitch, then a real '5'
        glitch();
        send_str("5123456789abcdef0123456789abcdef");
        check_phase("t4");
        check("t4_const", last_blk, 128'h5123456789abcdef0123456789abcdef);

        // Framing error on 'A', then recovery
        send_byte("A", 1'b0, 1'b0);
        send_str("0f1e2d3c4b5a69788796a5b4c3d2e1f0");
        check_phase("t5");
        check("t5_const", last_blk, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);

        // Reset mid-block loses the partial word
        send_str("0123456789ABCDEF0123");
        pulse_reset("t6rst");
        send_str("FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF");
        check_phase("t6");
        check("t6_const", last_blk, {128{1'b1}});

        // Random mix of digits, line ends, junk bytes, framing errors and glitches
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      send_byte(hexs[$urandom_range(0, 21)], 1'b1, 1'b0);
            else if (r < 78) send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A, 1'b1, 1'b0);
            else if (r < 88) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            else if (r < 95) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            else             glitch();
        end
        check_phase("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
